// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and state encoding (also used by uart_rx)
package uart_pkg;
   localparam int SYS_FRE    = 24_000_000;
   localparam int BPS        = 115200;
   localparam int BIT_CLKS   = SYS_FRE / BPS;
   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = 8;
   // Parity accumulator seed: 0 makes the parity bit the XOR of the data (even parity)
   localparam logic PAR_INIT = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - per-bit tick generator, held at zero while not running
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int BIT_CLKS_P = BIT_CLKS
) (
   input  logic clk24m,
   input  logic rst,
   input  logic run,
   output logic bit_tick
);
   localparam int CW = $clog2(BIT_CLKS_P);

   logic [CW-1:0] cnt;

   assign bit_tick = run && (cnt == CW'(BIT_CLKS_P - 1));

   always_ff @(posedge clk24m or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!run || bit_tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: holding register, 8E1/8E2 framing, overrun flag
module uart_tx
   import uart_pkg::*;
#(
   parameter int STOP_BITS = 1
) (
   input  logic       clk24m,
   input  logic       rst,
   input  logic       wrn,
   input  logic [7:0] din,
   output logic       tx_dat,
   output logic       thr_empty,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       ovr_err
);
   tx_state_t  state, state_nxt;
   logic       wrn_d;
   logic       wr_evt, accept, load;
   logic [7:0] thr;
   logic       thr_valid;
   logic [7:0] tsr, tsr_nxt;
   logic       par, par_nxt;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic       tx_dat_nxt;
   logic       bit_tick;

   uart_baud_tick #(
      .BIT_CLKS_P(BIT_CLKS)
   ) u_baud (
      .clk24m  (clk24m),
      .rst     (rst),
      .run     (state != ST_IDLE),
      .bit_tick(bit_tick)
   );

   assign wr_evt    = !wrn && wrn_d;
   // A load empties thr on this edge, so a coincident write still fits
   assign accept    = wr_evt && (!thr_valid || load);
   assign ovr_err   = wr_evt && !accept;
   assign thr_empty = !thr_valid;
   assign tx_busy   = (state != ST_IDLE);

   always_comb begin
      state_nxt   = state;
      tsr_nxt     = tsr;
      par_nxt     = par;
      bit_cnt_nxt = bit_cnt;
      load        = 1'b0;
      tx_done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (thr_valid)
               load = 1'b1;
         end
         ST_START: begin
            if (bit_tick)
               state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (bit_tick) begin
               tsr_nxt = {1'b0, tsr[7:1]};
               par_nxt = par ^ tsr[0];
               if (bit_cnt == 3'(DATA_BITS - 1))
                  state_nxt = ST_PARITY;
               else
                  bit_cnt_nxt = bit_cnt + 3'd1;
            end
         end
         ST_PARITY: begin
            if (bit_tick)
               state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (bit_tick) begin
               if (bit_cnt == 3'(STOP_BITS - 1)) begin
                  tx_done = 1'b1;
                  if (thr_valid)
                     load = 1'b1;
                  else
                     state_nxt = ST_IDLE;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (load) begin
         state_nxt = ST_START;
         tsr_nxt   = thr;
         par_nxt   = PAR_INIT;
      end
      if (state_nxt != state)
         bit_cnt_nxt = '0;

      // Line level is decided from the next state so tx_dat can be a plain flop
      case (state_nxt)
         ST_START:  tx_dat_nxt = 1'b0;
         ST_DATA:   tx_dat_nxt = tsr_nxt[0];
         ST_PARITY: tx_dat_nxt = par_nxt;
         default:   tx_dat_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk24m or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         wrn_d     <= 1'b1;
         thr       <= '0;
         thr_valid <= 1'b0;
         tsr       <= '0;
         par       <= 1'b0;
         bit_cnt   <= '0;
         tx_dat    <= 1'b1;
      end else begin
         state   <= state_nxt;
         wrn_d   <= wrn;
         tsr     <= tsr_nxt;
         par     <= par_nxt;
         bit_cnt <= bit_cnt_nxt;
         tx_dat  <= tx_dat_nxt;
         if (accept) begin
            thr       <= din;
            thr_valid <= 1'b1;
         end else if (load) begin
            thr_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-position model
module tb_uart_tx;
   import uart_pkg::*;

   localparam int BC = BIT_CLKS;
   localparam int FC = FRAME_BITS * BC;

   logic       clk24m = 1'b0;
   logic       rst    = 1'b1;
   logic       wrn    = 1'b1;
   logic [7:0] din    = 8'h00;
   logic       tx_dat, thr_empty, tx_busy, tx_done, ovr_err;

   uart_tx #(.STOP_BITS(1)) dut (
      .clk24m   (clk24m),
      .rst      (rst),
      .wrn      (wrn),
      .din      (din),
      .tx_dat   (tx_dat),
      .thr_empty(thr_empty),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .ovr_err  (ovr_err)
   );

   always #5 clk24m = ~clk24m;

   int     n_chk = 0;
   int     n_pass = 0;
   longint cyc = 0;
   longint wr_cyc = 0;

   always @(posedge clk24m) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Model: one byte of holding storage plus a position counter inside an 11-bit frame
   logic        m_wrn_d  = 1'b1;
   logic        m_hold_v = 1'b0;
   logic [7:0]  m_hold   = 8'h00;
   logic        m_active = 1'b0;
   int          m_pos    = 0;
   logic [10:0] m_frame  = 11'h7ff;
   logic [7:0]  exp_q[$];

   wire m_last   = m_active && (m_pos == FC - 1);
   wire m_load   = m_hold_v && (!m_active || m_last);
   wire m_evt    = !wrn && m_wrn_d;
   wire m_accept = m_evt && (!m_hold_v || m_load);
   wire m_tx     = m_active ? m_frame[m_pos / BC] : 1'b1;
   wire [4:0] m_exp = {m_tx, !m_hold_v, m_active, m_last, m_evt && !m_accept};

   always @(posedge clk24m or posedge rst) begin
      if (rst) begin
         m_wrn_d  <= 1'b1;
         m_hold_v <= 1'b0;
         m_active <= 1'b0;
         m_pos    <= 0;
         exp_q.delete();
      end else begin
         m_wrn_d <= wrn;
         if (m_load) begin
            m_active <= 1'b1;
            m_pos    <= 0;
            m_frame  <= {1'b1, ^m_hold, m_hold, 1'b0};
            exp_q.push_back(m_hold);
         end else if (m_last) begin
            m_active <= 1'b0;
         end else if (m_active) begin
            m_pos <= m_pos + 1;
         end
         if (m_accept) begin
            m_hold   <= din;
            m_hold_v <= 1'b1;
         end else if (m_load) begin
            m_hold_v <= 1'b0;
         end
      end
   end

   int     done_cnt = 0, busy_cnt = 0, ovr_cnt = 0;
   longint done_q[$];

   always @(negedge clk24m) begin
      if (!rst) begin
         check("cycle_outputs", {tx_dat, thr_empty, tx_busy, tx_done, ovr_err}, m_exp);
         if (tx_done) begin
            done_cnt++;
            done_q.push_back(cyc);
         end
         if (tx_busy) busy_cnt++;
         if (ovr_err) ovr_cnt++;
      end
   end

   // Receiver view: sample mid-bit and compare whole frames with accepted bytes in order
   logic        dec_on = 1'b0;
   int          dec_t = 0;
   int          dec_cnt = 0;
   logic [10:0] dec_bits = '0;
   logic [7:0]  dec_last = '0;

   always @(negedge clk24m) begin
      int k;
      logic [7:0] e;
      if (rst) begin
         dec_on = 1'b0;
      end else if (!dec_on) begin
         if (tx_dat == 1'b0) begin
            dec_on = 1'b1;
            dec_t  = 0;
         end
      end else begin
         dec_t++;
         if (dec_t % BC == BC / 2) begin
            k = dec_t / BC;
            dec_bits[k] = tx_dat;
            if (k == FRAME_BITS - 1) begin
               if (exp_q.size() == 0) begin
                  check("frame_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_decode", dec_bits, {1'b1, ^e, e, 1'b0});
               end
               dec_cnt++;
               dec_last = dec_bits[8:1];
               dec_on = 1'b0;
            end
         end
      end
   end

   task automatic wr(input logic [7:0] b, input int hold);
      @(posedge clk24m);
      #1 wrn = 1'b0;
      din = b;
      @(posedge clk24m);
      #1 wr_cyc = cyc;
      repeat (hold - 1) @(posedge clk24m);
      #1 wrn = 1'b1;
   endtask

   task automatic wait_fall(input int budget);
      int n = 0;
      while (tx_dat !== 1'b0 && n < budget) begin
         @(negedge clk24m);
         n++;
      end
      check("fall_timeout", tx_dat == 1'b0, 1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(tx_busy == 1'b0 && thr_empty == 1'b1) && n < budget) begin
         @(negedge clk24m);
         n++;
      end
      check("idle_timeout", (tx_busy == 1'b0) && (thr_empty == 1'b1), 1);
   endtask

   task automatic send_check(input logic [7:0] b, input logic [10:0] expf);
      logic [10:0] got;
      done_cnt = 0;
      busy_cnt = 0;
      done_q.delete();
      wr(b, 1);
      wait_fall(50);
      repeat (BC / 2) @(negedge clk24m);
      got[0] = tx_dat;
      for (int i = 1; i < FRAME_BITS; i++) begin
         repeat (BC) @(negedge clk24m);
         got[i] = tx_dat;
      end
      wait_idle(3000);
      check("line_bits", got, expf);
      check("done_count", done_cnt, 1);
      check("done_latency", (done_q.size() > 0) ? done_q[0] - wr_cyc : -1, FC);
      check("busy_cycles", busy_cnt, FC);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int z, d0, n;
      repeat (3) @(posedge clk24m);
      @(negedge clk24m);
      check("reset_values", {tx_dat, thr_empty, tx_busy, tx_done, ovr_err}, 5'b11000);
      @(posedge clk24m);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk24m);

      send_check(8'h55, {1'b1, 1'b0, 8'h55, 1'b0});
      send_check(8'h07, {1'b1, 1'b1, 8'h07, 1'b0});

      done_cnt = 0;
      busy_cnt = 0;
      done_q.delete();
      wr(8'hA3, 1);
      repeat (600) @(posedge clk24m);
      wr(8'h3C, 2);
      wait_idle(6000);
      check("b2b_done_count", done_cnt, 2);
      check("b2b_gap", (done_q.size() == 2) ? done_q[1] - done_q[0] : -1, FC);
      check("b2b_busy", busy_cnt, 2 * FC);

      d0 = dec_cnt;
      wr(8'h11, 1);
      repeat (300) @(posedge clk24m);
      wr(8'h22, 1);
      repeat (50) @(posedge clk24m);
      ovr_cnt = 0;
      wr(8'hFF, 3);
      repeat (5) @(posedge clk24m);
      check("ovr_pulses", ovr_cnt, 1);
      wait_idle(6000);
      check("ovr_frames", dec_cnt - d0, 2);
      check("ovr_last_byte", dec_last, 8'h22);

      wr(8'h5A, 1);
      wait_fall(50);
      repeat (5 * BC + 100) @(negedge clk24m);
      #3 rst = 1'b1;
      #1;
      check("reset_line_high", tx_dat, 1);
      check("reset_not_busy", tx_busy, 0);
      repeat (3) @(posedge clk24m);
      #1 rst = 1'b0;
      z = 0;
      repeat (3000) begin
         @(negedge clk24m);
         if (!tx_dat) z++;
      end
      check("idle_after_reset", z, 0);
      send_check(8'h81, {1'b1, 1'b0, 8'h81, 1'b0});

      for (int i = 0; i < 14; i++) begin
         n = 0;
         while (!thr_empty && n < 5000) begin
            @(negedge clk24m);
            n++;
         end
         check("thr_wait", thr_empty, 1);
         repeat ($urandom_range(0, 800)) @(posedge clk24m);
         wr(8'($urandom_range(0, 255)), $urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0)
            wr(8'($urandom_range(0, 255)), 1);
      end
      wait_idle(6000);
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
